// File: rtl/md_sequencer.sv
// md_sequencer: iterative HI/LO multiply/divide unit for the EX stage.
// In: clk, reset, Start/OpCode/Funct (EX decode), A (rs), B (rt).
// Out: Stall (comb), Busy, Done, Hi, Lo, MdResult (comb mfhi/mflo read).
module md_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] MdResult
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] accHi;
  logic [31:0] accLo;
  logic [31:0] opB;
  logic        isDiv;
  logic        negQ;
  logic        negR;
  logic        divZero;

  logic isR;
  logic opMult, opMultu, opDiv, opDivu;
  logic opMfhi, opMthi, opMflo, opMtlo;
  logic isMd, launch, signedOp, divOp;

  assign isR     = Start && (OpCode == 6'h00);
  assign opMult  = isR && (Funct == 6'h18);
  assign opMultu = isR && (Funct == 6'h19);
  assign opDiv   = isR && (Funct == 6'h1A);
  assign opDivu  = isR && (Funct == 6'h1B);
  assign opMfhi  = isR && (Funct == 6'h10);
  assign opMthi  = isR && (Funct == 6'h11);
  assign opMflo  = isR && (Funct == 6'h12);
  assign opMtlo  = isR && (Funct == 6'h13);

  assign launch   = opMult | opMultu | opDiv | opDivu;
  assign isMd     = launch | opMfhi | opMthi
                  | opMflo | opMtlo;
  assign signedOp = opMult | opDiv;
  assign divOp    = opDiv | opDivu;

  assign Stall = isMd && Busy;

  always_comb begin
    MdResult = 32'd0;
    if (opMfhi)
      MdResult = Hi;
    else if (opMflo)
      MdResult = Lo;
  end

  // Multiply: {accHi,accLo} holds partial product
  // above the not-yet-consumed multiplier bits.
  // Divide: accHi is the partial remainder, accLo
  // shifts dividend bits out and quotient bits in.
  logic [32:0] sum;
  logic [32:0] rem;
  logic [32:0] diff;
  logic [63:0] prod;

  assign sum  = {1'b0, accHi}
              + (accLo[0] ? {1'b0, opB} : 33'd0);
  assign rem  = {accHi, accLo[31]};
  assign diff = rem - {1'b0, opB};
  assign prod = {accHi, accLo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      cnt     <= 6'd0;
      accHi   <= 32'd0;
      accLo   <= 32'd0;
      opB     <= 32'd0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            launch: begin
              accHi   <= 32'd0;
              accLo   <= (signedOp && A[31]) ? -A : A;
              opB     <= (signedOp && B[31]) ? -B : B;
              isDiv   <= divOp;
              negQ    <= signedOp && (A[31] ^ B[31]);
              negR    <= signedOp && A[31];
              divZero <= (B == 32'd0);
              cnt     <= 6'd0;
              state   <= RUN;
              Busy    <= 1'b1;
            end
            opMthi:  Hi <= A;
            opMtlo:  Lo <= A;
            default: ;
          endcase
        end
        RUN: begin
          if (isDiv) begin
            if (!diff[32]) begin
              accHi <= diff[31:0];
              accLo <= {accLo[30:0], 1'b1};
            end else begin
              accHi <= rem[31:0];
              accLo <= {accLo[30:0], 1'b0};
            end
          end else begin
            {accHi, accLo} <= {sum, accLo[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
            Done  <= 1'b1;
          end
        end
        FIX: begin
          if (isDiv) begin
            Hi <= negR ? -accHi : accHi;
            Lo <= divZero ? 32'hFFFF_FFFF
                : (negQ ? -accLo : accLo);
          end else begin
            {Hi, Lo} <= negQ ? -prod : prod;
          end
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous reset, active-high.
REQ-003 SHALL have port: Start  in  1  EX-stage instruction valid and not flushed.
REQ-004 SHALL have port: OpCode  in  6  EX-stage opcode.
REQ-005 SHALL have port: Funct  in  6  EX-stage funct field.
REQ-006 SHALL have port: A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-007 SHALL have port: B  in  32  rt operand (divisor / multiplier).
REQ-008 SHALL have port: Stall  out  1  freeze IF/ID/EX; combinational.
REQ-009 SHALL have port: Busy  out  1  operation in progress; registered.
REQ-010 SHALL have port: Done  out  1  high during final (FIX) cycle only.
REQ-011 SHALL have port: Hi  out  32  HI register.
REQ-012 SHALL have port: Lo  out  32  LO register.
REQ-013 SHALL have port: MdResult  out  32  mfhi -> Hi, mflo -> Lo, else 0; combinational.

Function
REQ-014 SHALL decode only when Start=1 and OpCode=6'h00: mult 18, multu 19, div 1A, divu 1B, mfhi 10, mthi 11, mflo 12, mtlo 13 (hex); all other encodings SHALL be ignored.
REQ-015 SHALL implement FSM states IDLE, RUN, FIX; Busy=1 in RUN and FIX only.
REQ-016 In IDLE, a mult/multu/div/divu that is not stalled SHALL latch |A|, |B| (signed ops) or A, B (unsigned) plus result signs, clear the 6-bit iteration counter, and enter RUN.
REQ-017 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly 32 cycles, then enter FIX.
REQ-018 FIX SHALL apply sign correction, write Hi/Lo at the FIX clock edge, assert Done, and return to IDLE.
REQ-019 Latency: launch at edge N; Busy high for cycles N+1..N+33; Hi/Lo new value visible from cycle N+34.
REQ-020 Multiply SHALL produce {Hi,Lo} = 64-bit product; signed product negated when operand signs differ.
REQ-021 Divide SHALL produce Lo=quotient, Hi=remainder; quotient negated when signs differ; remainder takes the sign of A.
REQ-022 Divide by zero (B=0, signed or unsigned) SHALL yield Lo=32'hFFFFFFFF, Hi=A.
REQ-023 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield Lo=32'h80000000, Hi=0.
REQ-024 mthi/mtlo in IDLE and not stalled SHALL write A into Hi/Lo at that edge; no state change.
REQ-025 Stall SHALL equal Start AND (any opcode of REQ-014) AND Busy; Stall=0 when Busy=0.
REQ-026 A stalled instruction SHALL have no side effect; it is re-presented by the pipeline and accepted in the first cycle with Busy=0.
REQ-027 MdResult SHALL reflect Hi/Lo current register values; mfhi/mflo issued while Busy SHALL stall per REQ-025.
REQ-028 Hi/Lo SHALL be unchanged during RUN; intermediate values reside in internal registers only.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0, from any state including mid-RUN; the in-flight operation is discarded.
REQ-030 While reset=1, Start SHALL be ignored; Stall SHALL be 0 in the cycle after reset.

Verification
REQ-031 mult A=32'hFFFFFFFE (-2), B=3 at edge N -> Busy 1 for N+1..N+33, Done at N+33, Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA at N+34.
REQ-032 divu A=100, B=7 -> Lo=14, Hi=2; div A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
REQ-033 div A=5, B=0 -> Lo=32'hFFFFFFFF, Hi=5; div 32'h80000000 / -1 -> Lo=32'h80000000, Hi=0.
REQ-034 multu launched, mflo presented at N+5 -> Stall=1 for cycles N+5..N+33, Stall=0 at N+34 with MdResult = new Lo.
REQ-035 mthi A=32'h1234 in IDLE -> Hi=32'h1234 next cycle, Busy stays 0; second mult presented while Busy -> Stall=1, first result unaffected.
REQ-036 reset asserted at N+10 of a div -> next cycle Busy=0, Hi=Lo=0, Done never pulses.
